// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared constants and helpers for the programmable clock divider.
//   DIV_W_DEFAULT : default width of divisor and period counter
//   MIN_DIV       : smallest legal divisor; anything below is raised to it
//   clamp_div()   : max(value, MIN_DIV), evaluated on 32-bit unsigned values
// -----------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int unsigned DIV_W_DEFAULT = 8;
  localparam logic [31:0] MIN_DIV       = 32'd2;

  // Callers zero-extend their DIV_W-bit value to 32 bits and cast the result
  // back, so one helper serves every divisor width.
  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

endpackage : clkdiv_pkg

// File: rtl/clkdiv_halfext.sv
// -----------------------------------------------------------------------------
// clkdiv_halfext
// Half-cycle extender for odd divisors. A falling-edge copy of the rising-edge
// clk_out term is OR-ed onto that term, so the high phase lasts N/2 clk
// periods for odd N. Even divisors pass the term through untouched.
// The whole module only exists when CLKDIV_ODD_DUTY50_EN is defined; the
// default build contains no falling-edge flops at all.
// Ports:
//   clk       in  system clock (falling edge used here)
//   reset     in  asynchronous, active-low reset
//   term_i    in  rising-edge registered clk_out term
//   odd_i     in  1 when the active divisor is odd
//   clk_out_o out extended divided output
// -----------------------------------------------------------------------------
`ifdef CLKDIV_ODD_DUTY50_EN
module clkdiv_halfext (
  input  logic clk,
  input  logic reset,
  input  logic term_i,
  input  logic odd_i,
  output logic clk_out_o
);

  logic neg_q;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) neg_q <= 1'b0;
    else        neg_q <= term_i;
  end

  // The falling-edge copy rises and falls half a cycle after term_i, so the
  // OR stretches the high phase by exactly half a clk period.
  assign clk_out_o = term_i | (odd_i & neg_q);

endmodule : clkdiv_halfext
`endif

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Runtime-programmable integer clock divider. Produces a divided clock-like
// output and a one-cycle period strobe, both in the clk domain. New divisors
// are held pending and only take effect at a period boundary (wrap), so a
// period is never cut short or stretched mid-way.
// Optional build macro: CLKDIV_ODD_DUTY50_EN -- adds a falling-edge extender
// giving 50% duty for odd divisors too (see clkdiv_halfext).
// Parameters:
//   DIV_W     width of divisor and counter
//   RESET_DIV divisor after reset (clamped to >= 2)
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-low reset
//   en       in  count enable; low freezes the divider
//   div_val  in  new divisor, sampled when div_wr=1
//   div_wr   in  single-cycle write strobe
//   div_pend out a written divisor is waiting for the next wrap
//   clk_out  out divided output, period = active divisor
//   tick     out one-cycle strobe at the start of each period
// -----------------------------------------------------------------------------
module clk_div_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W     = DIV_W_DEFAULT,
  parameter int unsigned RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_wr,
  output logic             div_pend,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] RESET_DIV_C = DIV_W'(clamp_div(32'(RESET_DIV)));
  localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;         // active divisor
  logic [DIV_W-1:0] cnt_q, cnt_d;         // position inside the period
  logic [DIV_W-1:0] pend_q, pend_d;       // pending divisor value
  logic             div_pend_q, div_pend_d;
  logic             tick_q, tick_d;
  logic             term_q, term_d;       // rising-edge clk_out term

  logic [DIV_W-1:0] wr_val;
  logic             wrap;

  assign wr_val = DIV_W'(clamp_div(32'(div_val)));
  assign wrap   = en && (cnt_q == div_q - ONE);

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    div_pend_d = div_pend_q;
    tick_d     = 1'b0;

    if (wrap) begin
      cnt_d      = '0;
      tick_d     = 1'b1;
      div_pend_d = 1'b0;
      // A write landing on the wrap edge wins over an older pending value.
      if (div_wr)          div_d = wr_val;
      else if (div_pend_q) div_d = pend_q;
    end else begin
      if (en) cnt_d = cnt_q + ONE;
      if (div_wr) begin
        pend_d     = wr_val;
        div_pend_d = 1'b1;
      end
    end

    // Derived from next-state values so the registered output lines up with
    // the count it describes.
    term_d = (cnt_d < (div_d >> 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= RESET_DIV_C;
      cnt_q      <= RESET_DIV_C - ONE;  // first enabled edge is a wrap
      pend_q     <= RESET_DIV_C;
      div_pend_q <= 1'b0;
      tick_q     <= 1'b0;
      term_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      div_pend_q <= div_pend_d;
      tick_q     <= tick_d;
      term_q     <= term_d;
    end
  end

  assign div_pend = div_pend_q;
  assign tick     = tick_q;

`ifdef CLKDIV_ODD_DUTY50_EN
  clkdiv_halfext u_halfext (
    .clk       (clk),
    .reset     (reset),
    .term_i    (term_q),
    .odd_i     (div_q[0]),
    .clk_out_o (clk_out)
  );
`else
  assign clk_out = term_q;
`endif

endmodule : clk_div_prog

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Self-checking bench for clk_div_prog. A period-position reference model
// (which cycle of the current period we are in, the active divisor and any
// pending divisor) predicts tick, clk_out and div_pend after every edge.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  localparam int DIV_W     = 8;
  localparam int RESET_DIV = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_wr;
  logic             div_pend;
  logic             clk_out;
  logic             tick;

  int tests    = 0;
  int failures = 0;

  // Reference model state
  int m_n;        // active period length
  int m_pos;      // cycle index inside the current period
  bit m_pend;     // a divisor is waiting
  int m_pend_v;   // waiting divisor
  bit m_tick;
  bit m_term;     // rising-edge high phase expectation
  bit m_prev;     // term before the last edge (falling-edge copy)

  clk_div_prog #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_val  (div_val),
    .div_wr   (div_wr),
    .div_pend (div_pend),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n    = clampi(RESET_DIV);
    m_pos  = m_n - 1;
    m_pend = 1'b0;
    m_tick = 1'b0;
    m_term = 1'b0;
    m_prev = 1'b0;
  endtask

  // One rising edge of the reference: a period ends after m_n enabled cycles.
  task automatic model_step(input bit e, input bit w, input int v);
    m_prev = m_term;
    m_tick = 1'b0;
    if (e && (m_pos + 1 == m_n)) begin
      if (w)           m_n = clampi(v);
      else if (m_pend) m_n = m_pend_v;
      m_pend = 1'b0;
      m_pos  = 0;
      m_tick = 1'b1;
    end else begin
      if (e) m_pos++;
      if (w) begin
        m_pend   = 1'b1;
        m_pend_v = clampi(v);
      end
    end
    m_term = (m_pos < m_n / 2);
  endtask

  function automatic bit exp_clk_out();
`ifdef CLKDIV_ODD_DUTY50_EN
    return m_term | ((m_n % 2 == 1) & m_prev);
`else
    return m_term;
`endif
  endfunction

  task automatic check_all(input string tag);
    check($sformatf("%s tick t=%0t", tag, $time), tick, m_tick);
    check($sformatf("%s clk_out t=%0t", tag, $time), clk_out, exp_clk_out());
    check($sformatf("%s div_pend t=%0t", tag, $time), div_pend, m_pend);
  endtask

  // Drive one cycle of inputs, advance one edge, compare.
  task automatic cycle(input string tag, input bit e, input bit w, input int v);
    en      = e;
    div_wr  = w;
    div_val = DIV_W'(v);
    @(posedge clk);
    model_step(e, w, v);
    #1;
    check_all(tag);
  endtask

  initial begin
    int guard;
    reset   = 1'b0;
    en      = 1'b0;
    div_wr  = 1'b0;
    div_val = '0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // Default divide-by-3: tick every 3, clk_out 1,0,0
    repeat (9) cycle("div3", 1, 0, 0);

    // Write 4 in the middle of a period (cnt=1)
    cycle("div3b", 1, 0, 0);
    cycle("wr4", 1, 1, 4);
    repeat (10) cycle("div4", 1, 0, 0);

    // Writes of 0 and 1 both clamp to 2
    cycle("wr0", 1, 1, 0);
    repeat (6) cycle("div2a", 1, 0, 0);
    cycle("wr1", 1, 1, 1);
    repeat (6) cycle("div2b", 1, 0, 0);

    // Move to 7, then 5 overwritten by 6 before the wrap
    cycle("wr7", 1, 1, 7);
    repeat (4) cycle("div7a", 1, 0, 0);
    cycle("wr5", 1, 1, 5);
    cycle("wr6", 1, 1, 6);
    repeat (14) cycle("div6", 1, 0, 0);

    // Write coincident with a wrap applies immediately, no pending phase
    cycle("wr3", 1, 1, 3);
    guard = 0;
    while (m_pos != m_n - 1 && guard < 300) begin
      cycle("align", 1, 0, 0);
      guard++;
    end
    cycle("wr6wrap", 1, 1, 6);
    repeat (8) cycle("div6w", 1, 0, 0);

    // Freeze for 4 cycles mid-period, then resume the same period
    repeat (2) cycle("prefrz", 1, 0, 0);
    repeat (4) cycle("frz", 0, 0, 0);
    repeat (8) cycle("resume", 1, 0, 0);

    // Write 5 while frozen, then run with odd divisor
    cycle("wr5frz", 0, 1, 5);
    repeat (15) cycle("div5", 1, 0, 0);

    // Asynchronous reset mid-period with a write pending
    cycle("wr9", 1, 1, 9);
    @(posedge clk);
    model_step(1'b1, 1'b0, 0);
    en = 1'b0; div_wr = 1'b0;
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("in_rst");
    reset = 1'b1;
    repeat (9) cycle("post_rst", 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit e, w;
      int v;
      e = ($urandom_range(0, 9) < 8);
      w = ($urandom_range(0, 99) < 12);
      v = $urandom_range(0, 12);
      cycle("rand", e, w, v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule : tb_clk_div_prog
